// File: rtl/header_creator_pkg.sv
// Shared types and constants for the header-creator packet interface.
// Holds the transmit-source state encoding and default sizing.
package header_creator_pkg;

  localparam int HC_BUS_WIDTH_BITS = 32;

  localparam int HC_TX_MAX_BEATS  = 16;
  localparam int HC_TX_GAP_CYCLES = 2;

  typedef enum logic [2:0] {
    TX_FILL,
    TX_DRAIN,
    TX_READY,
    TX_SOP,
    TX_STREAM,
    TX_GAP
  } HC_TX_STATES;

endpackage

// File: rtl/hc_tx_beat_buffer.sv
// Packet beat store for the transmit source.
// Flop array with one synchronous write port and an async read port.
module hc_tx_beat_buffer #(
    parameter int DEPTH = 16,
    parameter int W     = 32,
    parameter int AW    = 4
) (
    input  logic          CLK,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [W-1:0]  rd_data
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/hc_packet_tx_source.sv
// Stores one upstream packet and replays it to a header creator on request:
// SOP pulse, contiguous beats with EOP on the last, then a short idle gap.
module hc_packet_tx_source
    import header_creator_pkg::*;
#(
    parameter int BUS_W      = HC_BUS_WIDTH_BITS,
    parameter int MAX_BEATS  = HC_TX_MAX_BEATS,
    parameter int GAP_CYCLES = HC_TX_GAP_CYCLES
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             wr_valid_i,
    input  logic [BUS_W-1:0] wr_data_i,
    input  logic             wr_last_i,
    output logic             wr_ready_o,
    input  logic             packet_read_req_i,
    output logic             start_of_packet_o,
    output logic [BUS_W-1:0] packet_bus_o,
    output logic             beat_valid_o,
    output logic             end_of_packet_o,
    output logic             overflow_o,
    output logic [15:0]      tx_count_o
);

    localparam int AW = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
    localparam int PW = $clog2(MAX_BEATS) + 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    HC_TX_STATES state, state_n;

    logic [PW-1:0]    wr_ptr, wr_ptr_n;
    logic [PW-1:0]    rd_ptr, rd_ptr_n;
    logic [PW-1:0]    len, len_n;
    logic [GW-1:0]    gap_ctr, gap_ctr_n;
    logic [15:0]      tx_count, tx_count_n;
    logic             overflow_q, overflow_n;
    logic             mem_we;
    logic             accept;
    logic             last_beat;
    logic [BUS_W-1:0] rd_data;

    hc_tx_beat_buffer #(
        .DEPTH (MAX_BEATS),
        .W     (BUS_W),
        .AW    (AW)
    ) u_buf (
        .CLK     (CLK),
        .wr_en   (mem_we),
        .wr_addr (wr_ptr[AW-1:0]),
        .wr_data (wr_data_i),
        .rd_addr (rd_ptr[AW-1:0]),
        .rd_data (rd_data)
    );

    assign wr_ready_o = (state == TX_FILL) || (state == TX_DRAIN);
    assign accept     = wr_valid_i && wr_ready_o;
    assign last_beat  = (rd_ptr == len - PW'(1));

    always_comb begin
        state_n    = state;
        wr_ptr_n   = wr_ptr;
        rd_ptr_n   = rd_ptr;
        len_n      = len;
        gap_ctr_n  = gap_ctr;
        tx_count_n = tx_count;
        overflow_n = 1'b0;
        mem_we     = 1'b0;
        unique case (state)
            TX_FILL: begin
                if (accept) begin
                    mem_we   = 1'b1;
                    wr_ptr_n = wr_ptr + PW'(1);
                    if (wr_last_i) begin
                        len_n   = wr_ptr + PW'(1);
                        state_n = TX_READY;
                    end else if (wr_ptr == PW'(MAX_BEATS - 1)) begin
                        len_n      = PW'(MAX_BEATS);
                        overflow_n = 1'b1;
                        state_n    = TX_DRAIN;
                    end
                end
            end
            TX_DRAIN: begin
                if (accept && wr_last_i) begin
                    state_n = TX_READY;
                end
            end
            TX_READY: begin
                if (packet_read_req_i) begin
                    state_n = TX_SOP;
                end
            end
            TX_SOP: begin
                rd_ptr_n = '0;
                state_n  = TX_STREAM;
            end
            TX_STREAM: begin
                rd_ptr_n = rd_ptr + PW'(1);
                if (last_beat) begin
                    tx_count_n = tx_count + 16'd1;
                    gap_ctr_n  = '0;
                    if (GAP_CYCLES == 0) begin
                        wr_ptr_n = '0;
                        state_n  = TX_FILL;
                    end else begin
                        state_n = TX_GAP;
                    end
                end
            end
            TX_GAP: begin
                if (gap_ctr == GW'(GAP_CYCLES - 1)) begin
                    gap_ctr_n = '0;
                    wr_ptr_n  = '0;
                    state_n   = TX_FILL;
                end else begin
                    gap_ctr_n = gap_ctr + GW'(1);
                end
            end
            default: begin
                state_n = TX_FILL;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state      <= TX_FILL;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            len        <= '0;
            gap_ctr    <= '0;
            tx_count   <= '0;
            overflow_q <= 1'b0;
        end else begin
            state      <= state_n;
            wr_ptr     <= wr_ptr_n;
            rd_ptr     <= rd_ptr_n;
            len        <= len_n;
            gap_ctr    <= gap_ctr_n;
            tx_count   <= tx_count_n;
            overflow_q <= overflow_n;
        end
    end

    assign start_of_packet_o = (state == TX_SOP);
    assign beat_valid_o      = (state == TX_STREAM);
    assign end_of_packet_o   = beat_valid_o && last_beat;
    assign packet_bus_o      = beat_valid_o ? rd_data : '0;
    assign overflow_o        = overflow_q;
    assign tx_count_o        = tx_count;

endmodule
